lc3_datapath_p: RTL and testbench
=================================

# lc3_datapath_p

Parametrised LC-3 datapath: one shared bus fed by four gated sources, PC/IR/MAR/MDR registers, an 8-entry register file, an ALU, the address adder (MARMUX), condition codes and the branch-enable flag. It sits between the control FSM (which drives every LD_*/Gate*/select line) and the memory/IO tristate interface (MDR_In, MIO_EN). It extends the week-1 fetch-only datapath with full execute support, a configurable data width and a sticky bus-contention error.

## Interface
- WIDTH, 16, data/bus width; must be ≥16; instruction fields always sit in IR[15:0]
- RESET_PC, 0, value loaded into PC on reset

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus source gates
- MIO_EN  in  1  MDR input select: 1 = MDR_In, 0 = BUS
- PCMUX  in  2  00 PC+1, 01 BUS, 10 address adder, 11 hold PC
- DRMUX  in  1  0 = IR[11:9], 1 = R7
- SR1MUX  in  1  0 = IR[8:6], 1 = IR[11:9]
- ADDR1MUX  in  1  0 = PC, 1 = SR1
- ADDR2MUX  in  2  00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0]
- ALUK  in  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A
- MDR_In  in  WIDTH  data from memory/IO
- PC, MAR, MDR, IR  out  WIDTH  register contents
- BEN  out  1  branch enable
- LED  out  12  LED latch
- BUS_ERR  out  1  sticky bus contention flag

## Operation
- BUS: exactly one gate high selects PC, MDR, ALU out or adder out; no gate high → BUS = 0; more than one high → BUS = 0 and BUS_ERR sets.
- BUS_ERR stays set until reset; it does not block register loads.
- ALU: A = SR1; B = sext IR[4:0] when IR[5]=1, else SR2 (IR[2:0]). ADD wraps modulo 2^WIDTH, no carry out.
- Address adder = ADDR1MUX + ADDR2MUX, WIDTH bits, wraps.
- Sign extension replicates the field MSB up to WIDTH.
- Register file: 8 × WIDTH; two async reads (SR1, SR2), one sync write of BUS to DR on LD_REG.
- MDR ← MIO_EN ? MDR_In : BUS on LD_MDR. MAR, IR ← BUS on their loads.
- CC on LD_CC from BUS: N = BUS[WIDTH-1]; Z = (BUS==0); P = !N && !Z. Exactly one bit is set after any load.
- BEN on LD_BEN ← (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the current CC.
- LED ← IR[11:0] on LD_LED.
- PCMUX=11 with LD_PC keeps PC unchanged.

## Timing
- All state updates on the rising Clk edge. BUS, ALU and adder are combinational within the cycle.
- Reset (Reset=0, asynchronous): PC=RESET_PC; IR, MAR, MDR, every register = 0; CC=000; BEN=0; LED=0; BUS_ERR=0. Release is synchronous to the next edge.
- Reset asserted mid-operation overrides every pending load in that cycle.
- Read-during-write to the same register returns the old value. The new value is visible the next cycle.
- LD_CC and LD_BEN in the same cycle: BEN uses the pre-update CC.
- LD_IR with LD_BEN in the same cycle: BEN uses the old IR.
- PC+1 from PC = 2^WIDTH−1 wraps to 0.

## Structure
- Package lc3_pkg holds:
  - enums for PCMUX, ADDR2MUX and ALUK encodings
  - IR field-position constants (DR, SR1, SR2, imm5, offset6/9/11)
  - a parametrised sign-extend function
- Sub-module lc3_regfile: 8×WIDTH, async active-low reset, two read ports, one write port.
- Reuse the existing WIDTH-generalised load-enable register for PC, IR, MAR and MDR.

## Test plan
- Reset: drive Reset=0 mid-run with RESET_PC=16'h3000 → all outputs take their reset values, PC=16'h3000, BUS_ERR=0.
- Fetch: GatePC+LD_MAR, then MIO_EN+LD_MDR with MDR_In=16'h1261, then GateMDR+LD_IR → MAR=16'h3000, IR=16'h1261. PCMUX=00+LD_PC → PC=16'h3001.
- ADD imm: R1=5, IR=16'h1261 (R1←R1+1). GateALU+LD_REG+LD_CC → R1=6, CC=001. With R1=16'hFFFF → R1=0, CC=010.
- Branch: IR=16'h0402 (BRz), CC=010, LD_BEN → BEN=1. CC=001 → BEN=0. PCMUX=10, ADDR1MUX=0, ADDR2MUX=10 → PC=PC+2.
- Contention: GatePC and GateALU high together → BUS=0 and BUS_ERR=1. BUS_ERR stays 1 after 10 clean cycles and clears only on reset.
- WIDTH=32 build: IR=16'h103F (R0←R0+(−1)) with R0=0 → R0=32'hFFFF_FFFF, CC=100.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared encodings, IR field positions and sign extension for the LC-3 datapath
package lc3_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDR, PC_HOLD} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_e;
  localparam int DR_LSB = 9;
  localparam int SR1_LSB = 6;
  localparam int SR2_LSB = 0;
  localparam int IMM_SEL = 5;
  localparam int IMM5_W = 5;
  localparam int OFF6_W = 6;
  localparam int OFF9_W = 9;
  localparam int OFF11_W = 11;
  // Sign-extends the low n bits of f to MAX_W bits; callers truncate to their width.
  function automatic logic [MAX_W-1:0] sext(input logic [15:0] f, input int n);
    logic signed [MAX_W-1:0] t;
    t = $signed({f, {(MAX_W-16){1'b0}}}) <<< (16 - n);
    return t >>> (MAX_W - n);
  endfunction
endpackage

// File: rtl/lc3_reg.sv
// lc3_reg: WIDTH-bit load-enable register with asynchronous active-low reset
module lc3_reg #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // load d when enabled, reset to INIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= INIT;
    else if (ld) q <= d;
endmodule

// File: rtl/lc3_regfile.sv
// lc3_regfile: 8 x WIDTH register file, two async reads, one sync write
module lc3_regfile #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       wa,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       ra1,
  input  logic [2:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);
  logic [WIDTH-1:0] r [8];
  // write port; reads see the old value during a same-cycle write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 8; i++) r[i] <= '0;
    else if (we) r[wa] <= d;
  assign rd1 = r[ra1];
  assign rd2 = r[ra2];
endmodule

// File: rtl/lc3_datapath_p.sv
// lc3_datapath_p: parametrised LC-3 datapath with shared bus, regfile, ALU, address adder and CC/BEN
module lc3_datapath_p
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic             MIO_EN,
  input  logic [1:0]       PCMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic [WIDTH-1:0] MDR_In,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic             BEN,
  output logic [11:0]      LED,
  output logic             BUS_ERR
);
  logic [3:0] gates;
  logic multi;
  logic [WIDTH-1:0] bus, alu, addr, sr1, sr2, alu_b, addr1, addr2, pc_next;
  logic [WIDTH-1:0] imm5, off6, off9, off11;
  logic [2:0] sr1_a, dr, nzp;
  assign imm5 = WIDTH'(sext(IR[15:0], IMM5_W));
  assign off6 = WIDTH'(sext(IR[15:0], OFF6_W));
  assign off9 = WIDTH'(sext(IR[15:0], OFF9_W));
  assign off11 = WIDTH'(sext(IR[15:0], OFF11_W));
  assign sr1_a = SR1MUX ? IR[DR_LSB +: 3] : IR[SR1_LSB +: 3];
  assign dr = DRMUX ? 3'd7 : IR[DR_LSB +: 3];
  assign gates = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign multi = (gates & (gates - 4'd1)) != 4'd0;
  // bus source select, ALU, address adder and PC mux
  always_comb begin
    alu_b = IR[IMM_SEL] ? imm5 : sr2;
    alu = ALUK == ALU_ADD ? sr1 + alu_b : ALUK == ALU_AND ? sr1 & alu_b : ALUK == ALU_NOT ? ~sr1 : sr1;
    addr1 = ADDR1MUX ? sr1 : PC;
    addr2 = ADDR2MUX == A2_ZERO ? '0 : ADDR2MUX == A2_OFF6 ? off6 : ADDR2MUX == A2_OFF9 ? off9 : off11;
    addr = addr1 + addr2;
    bus = multi ? '0 : GatePC ? PC : GateMDR ? MDR : GateALU ? alu : GateMARMUX ? addr : '0;
    pc_next = PCMUX == PC_INC ? PC + WIDTH'(1) : PCMUX == PC_BUS ? bus : PCMUX == PC_ADDR ? addr : PC;
  end
  lc3_reg #(.WIDTH(WIDTH), .INIT(RESET_PC)) u_pc (.clk(Clk), .rst_n(Reset), .ld(LD_PC), .d(pc_next), .q(PC));
  lc3_reg #(.WIDTH(WIDTH)) u_ir (.clk(Clk), .rst_n(Reset), .ld(LD_IR), .d(bus), .q(IR));
  lc3_reg #(.WIDTH(WIDTH)) u_mar (.clk(Clk), .rst_n(Reset), .ld(LD_MAR), .d(bus), .q(MAR));
  lc3_reg #(.WIDTH(WIDTH)) u_mdr (.clk(Clk), .rst_n(Reset), .ld(LD_MDR), .d(MIO_EN ? MDR_In : bus), .q(MDR));
  lc3_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk(Clk), .rst_n(Reset), .we(LD_REG), .wa(dr), .d(bus),
    .ra1(sr1_a), .ra2(IR[SR2_LSB +: 3]), .rd1(sr1), .rd2(sr2)
  );
  // condition codes, branch enable (from pre-update CC/IR), LED latch and sticky contention flag
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      nzp <= '0;
      BEN <= 1'b0;
      LED <= '0;
      BUS_ERR <= 1'b0;
    end else begin
      if (LD_CC) nzp <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && bus != '0};
      if (LD_BEN) BEN <= |(IR[11:9] & nzp);
      if (LD_LED) LED <= IR[11:0];
      if (multi) BUS_ERR <= 1'b1;
    end
endmodule

// File: tb/tb_lc3_datapath_p.sv
// tb_lc3_datapath_p: scoreboard bench for 16- and 32-bit datapath builds
module tb_lc3_datapath_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux, mio_en, drmux, sr1mux, addr1mux;
  logic [1:0] pcmux, addr2mux, aluk;
  logic [15:0] mdr_in;
  logic [15:0] pc, mar, mdr, ir;
  logic [31:0] pc_w, mar_w, mdr_w, ir_w;
  logic ben, bus_err, ben_w, bus_err_w;
  logic [11:0] led, led_w;
  localparam int S_PC = 0, S_MAR = 1, S_MDR = 2, S_IR = 3, S_BEN = 4, S_LED = 5, S_ERR = 6;
  localparam int W_PC = 8, W_MAR = 9, W_IR = 11, W_BEN = 12, W_ERR = 14;

  lc3_datapath_p #(.WIDTH(16), .RESET_PC(16'h3000)) dut (
    .Clk(clk), .Reset(rst_n), .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
    .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led), .GatePC(gate_pc),
    .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux), .MIO_EN(mio_en),
    .PCMUX(pcmux), .DRMUX(drmux), .SR1MUX(sr1mux), .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux),
    .ALUK(aluk), .MDR_In(mdr_in), .PC(pc), .MAR(mar), .MDR(mdr), .IR(ir), .BEN(ben),
    .LED(led), .BUS_ERR(bus_err)
  );
  lc3_datapath_p #(.WIDTH(32), .RESET_PC(32'h3000)) dut_w (
    .Clk(clk), .Reset(rst_n), .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
    .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led), .GatePC(gate_pc),
    .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux), .MIO_EN(mio_en),
    .PCMUX(pcmux), .DRMUX(drmux), .SR1MUX(sr1mux), .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux),
    .ALUK(aluk), .MDR_In({16'h0, mdr_in}), .PC(pc_w), .MAR(mar_w), .MDR(mdr_w), .IR(ir_w),
    .BEN(ben_w), .LED(led_w), .BUS_ERR(bus_err_w)
  );

  typedef struct {
    string tag;
    int sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int passed = 0;
  int total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want_v);
    total++;
    if (got !== want_v) $display("FAIL %s: got %h expected %h", tag, got, want_v);
    else passed++;
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_PC: return {16'h0, pc};
      S_MAR: return {16'h0, mar};
      S_MDR: return {16'h0, mdr};
      S_IR: return {16'h0, ir};
      S_BEN: return {31'h0, ben};
      S_LED: return {20'h0, led};
      S_ERR: return {31'h0, bus_err};
      W_PC: return pc_w;
      W_MAR: return mar_w;
      W_IR: return ir_w;
      W_BEN: return {31'h0, ben_w};
      W_ERR: return {31'h0, bus_err_w};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic clr();
    {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '0;
    {gate_pc, gate_mdr, gate_alu, gate_marmux, mio_en, drmux, sr1mux, addr1mux} = '0;
    pcmux = 2'b00;
    addr2mux = 2'b00;
    aluk = 2'b00;
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
    clr();
  endtask

  initial begin
    clr();
    mdr_in = '0;
    want("rst_pc", S_PC, 32'h3000); want("rst_mar", S_MAR, 0); want("rst_mdr", S_MDR, 0);
    want("rst_ir", S_IR, 0); want("rst_ben", S_BEN, 0); want("rst_led", S_LED, 0);
    want("rst_err", S_ERR, 0);
    cyc();
    rst_n = 1'b1;
    // fetch
    gate_pc = 1; ld_mar = 1; want("fetch_mar", S_MAR, 32'h3000); cyc();
    mio_en = 1; ld_mdr = 1; mdr_in = 16'h1261; ld_pc = 1; pcmux = 2'b00;
    want("fetch_mdr", S_MDR, 32'h1261); want("pc_inc", S_PC, 32'h3001); cyc();
    gate_mdr = 1; ld_ir = 1; want("fetch_ir", S_IR, 32'h1261); cyc();
    // R1 = 5, then ADD imm
    mio_en = 1; ld_mdr = 1; mdr_in = 16'h0005; want("mdr5", S_MDR, 5); cyc();
    gate_mdr = 1; ld_reg = 1; want("err_clean", S_ERR, 0); cyc();
    gate_alu = 1; ld_reg = 1; ld_cc = 1; ld_mar = 1; ld_led = 1;
    want("add_6", S_MAR, 6); want("led", S_LED, 12'h261); cyc();
    gate_alu = 1; ld_reg = 1; ld_mar = 1; ld_ben = 1;
    want("add_7_rdw", S_MAR, 7); want("ben_p", S_BEN, 1); cyc();
    gate_alu = 1; aluk = 2'b11; ld_mar = 1; want("pass_r1", S_MAR, 7); cyc();
    // R1 = FFFF, ADD wraps to 0
    mio_en = 1; ld_mdr = 1; mdr_in = 16'hFFFF; cyc();
    gate_mdr = 1; ld_reg = 1; ld_cc = 1; cyc();
    ld_ben = 1; want("ben_n", S_BEN, 0); cyc();
    gate_alu = 1; ld_reg = 1; ld_cc = 1; ld_mar = 1; want("add_wrap", S_MAR, 0); cyc();
    // branch: BEN uses old IR / old CC
    mio_en = 1; ld_mdr = 1; mdr_in = 16'h0402; cyc();
    gate_mdr = 1; ld_ir = 1; ld_ben = 1;
    want("ir_brz", S_IR, 32'h0402); want("ben_old_ir", S_BEN, 0); cyc();
    gate_mdr = 1; ld_cc = 1; ld_ben = 1; want("ben_old_cc", S_BEN, 1); cyc();
    ld_ben = 1; want("ben_cc_p", S_BEN, 0); cyc();
    ld_pc = 1; pcmux = 2'b10; addr2mux = 2'b10; want("pc_off9", S_PC, 32'h3003); cyc();
    ld_pc = 1; pcmux = 2'b10; addr2mux = 2'b11; gate_marmux = 1; ld_mar = 1;
    want("pc_off11", S_PC, 32'h2C05); want("marmux", S_MAR, 32'h2C05); cyc();
    addr1mux = 1; addr2mux = 2'b01; gate_marmux = 1; ld_mar = 1; want("sr1_off6", S_MAR, 2); cyc();
    ld_pc = 1; pcmux = 2'b11; want("pc_hold", S_PC, 32'h2C05); cyc();
    ld_pc = 1; pcmux = 2'b01; gate_mdr = 1; want("pc_bus", S_PC, 32'h0402); cyc();
    // PC wrap
    mio_en = 1; ld_mdr = 1; mdr_in = 16'hFFFF; cyc();
    ld_pc = 1; pcmux = 2'b01; gate_mdr = 1; want("pc_ffff", S_PC, 32'hFFFF); cyc();
    ld_pc = 1; pcmux = 2'b00; want("pc_wrap", S_PC, 0); cyc();
    gate_alu = 1; aluk = 2'b10; ld_mar = 1; want("not_r0", S_MAR, 32'hFFFF); cyc();
    // contention
    gate_pc = 1; gate_alu = 1; ld_mar = 1; want("contend_bus", S_MAR, 0); want("contend_err", S_ERR, 1); cyc();
    repeat (10) cyc();
    want("err_sticky", S_ERR, 1); cyc();
    // reset mid-operation overrides loads
    gate_pc = 1; ld_mar = 1; ld_ir = 1; ld_pc = 1; ld_led = 1; ld_ben = 1; mio_en = 1; ld_mdr = 1;
    mdr_in = 16'h1234; rst_n = 1'b0;
    want("mrst_pc", S_PC, 32'h3000); want("mrst_mar", S_MAR, 0); want("mrst_mdr", S_MDR, 0);
    want("mrst_ir", S_IR, 0); want("mrst_led", S_LED, 0); want("mrst_err", S_ERR, 0);
    want("mrst_w_pc", W_PC, 32'h3000); want("mrst_w_err", W_ERR, 0);
    cyc();
    rst_n = 1'b1;
    // 32-bit build: R0 = 0 + sext(-1)
    mio_en = 1; ld_mdr = 1; mdr_in = 16'h103F; cyc();
    gate_mdr = 1; ld_ir = 1; want("w_ir", W_IR, 32'h103F); cyc();
    gate_alu = 1; ld_reg = 1; ld_cc = 1; ld_mar = 1;
    want("w_add", W_MAR, 32'hFFFF_FFFF); want("n_add16", S_MAR, 32'hFFFF); cyc();
    gate_alu = 1; aluk = 2'b11; ld_mar = 1; want("w_r0", W_MAR, 32'hFFFF_FFFF); cyc();
    mio_en = 1; ld_mdr = 1; mdr_in = 16'h0800; cyc();
    gate_mdr = 1; ld_ir = 1; cyc();
    ld_ben = 1; want("w_ben_n", W_BEN, 1); cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
